// File: rtl/tx_lp_hs_seq_pkg.sv
// Shared D-PHY lane definitions: sequencer states, LP line codes and default timings.
package dphy_pkg;

  typedef enum logic [2:0] {
    ST_STOP     = 3'd0,
    ST_HS_RQST  = 3'd1,
    ST_HS_PRPR  = 3'd2,
    ST_HS_ZERO  = 3'd3,
    ST_HS_SYNC  = 3'd4,
    ST_HS_DATA  = 3'd5,
    ST_HS_TRAIL = 3'd6,
    ST_HS_EXIT  = 3'd7
  } seq_state_e;

  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

  localparam int T_LPX_DEF        = 2;
  localparam int T_HS_PREPARE_DEF = 2;
  localparam int T_HS_ZERO_DEF    = 6;
  localparam int T_HS_TRAIL_DEF   = 3;
  localparam int T_HS_EXIT_DEF    = 4;

  // A count is usable only if its N-1 reload value fits the timer.
  function automatic bit t_ok(input int t, input int cnt_w);
    return (t >= 1) && (t < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/tx_lp_hs_seq_if.sv
// Lane-side bundle between a burst source (master) and the LP/HS sequencer (slave).
interface tx_lp_hs_seq_if #(
  parameter int DATA_W = 8
);
  logic              TX_REQ;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_READY;
  logic              Dp;
  logic              Dn;
  logic              HS_EN;
  logic [DATA_W-1:0] HS_DATA;
  logic              TX_HS_END_DATA;
  logic              TX_STOP_STATE;

  modport master (
    output TX_REQ, TX_DATA,
    input  TX_READY, Dp, Dn, HS_EN, HS_DATA, TX_HS_END_DATA, TX_STOP_STATE
  );

  modport slave (
    input  TX_REQ, TX_DATA,
    output TX_READY, Dp, Dn, HS_EN, HS_DATA, TX_HS_END_DATA, TX_STOP_STATE
  );
endinterface

// File: rtl/tx_lp_hs_seq_timer.sv
// Down-counting interval timer: load N-1 on state entry, zero flag marks the final cycle.
module dphy_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/tx_lp_hs_seq.sv
// D-PHY TX data-lane burst sequencer: STOP > RQST > PRPR > ZERO > SYNC > DATA > TRAIL > EXIT.
// Line outputs are Moore decodes of the state; HS_DATA is a register loaded for the next state.
module tx_lp_hs_seq
  import dphy_pkg::*;
#(
  parameter int         DATA_W       = 8,
  parameter int         CNT_W        = 8,
  parameter int         T_LPX        = T_LPX_DEF,
  parameter int         T_HS_PREPARE = T_HS_PREPARE_DEF,
  parameter int         T_HS_ZERO    = T_HS_ZERO_DEF,
  parameter int         T_HS_TRAIL   = T_HS_TRAIL_DEF,
  parameter int         T_HS_EXIT    = T_HS_EXIT_DEF,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input logic          TX_BYTE_clk,
  input logic          TX_rst,
  tx_lp_hs_seq_if.slave lane
);

  if (DATA_W != 8 && DATA_W != 16) begin : g_bad_data_w
    $error("tx_lp_hs_seq: DATA_W must be 8 or 16");
  end
  if (!t_ok(T_LPX, CNT_W) || !t_ok(T_HS_PREPARE, CNT_W) || !t_ok(T_HS_ZERO, CNT_W) ||
      !t_ok(T_HS_TRAIL, CNT_W) || !t_ok(T_HS_EXIT, CNT_W)) begin : g_bad_timing
    $error("tx_lp_hs_seq: every T_* must be in 1 .. 2**CNT_W-1");
  end

  seq_state_e        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_hs_data, w_hs_data_nxt;
  logic              w_tmr_zero, w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_val;
  logic [1:0]        w_lp;
  logic              w_hs_en, w_ready, w_stop, w_end, w_accept;

  always_ff @(posedge TX_BYTE_clk) begin
    if (TX_rst) begin
      r_state   <= ST_STOP;
      r_hs_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hs_data <= w_hs_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_STOP;
    w_lp        = LP11;
    w_hs_en     = 1'b0;
    w_ready     = 1'b0;
    w_stop      = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      ST_STOP: begin
        w_stop      = 1'b1;
        w_state_nxt = lane.TX_REQ ? ST_HS_RQST : ST_STOP;
      end
      ST_HS_RQST: begin
        w_lp        = LP01;
        w_state_nxt = w_tmr_zero ? ST_HS_PRPR : ST_HS_RQST;
      end
      ST_HS_PRPR: begin
        w_lp        = LP00;
        w_state_nxt = w_tmr_zero ? ST_HS_ZERO : ST_HS_PRPR;
      end
      ST_HS_ZERO: begin
        w_lp        = LP00;
        w_hs_en     = 1'b1;
        w_state_nxt = w_tmr_zero ? ST_HS_SYNC : ST_HS_ZERO;
      end
      ST_HS_SYNC, ST_HS_DATA: begin
        w_lp        = LP00;
        w_hs_en     = 1'b1;
        w_ready     = 1'b1;
        w_state_nxt = lane.TX_REQ ? ST_HS_DATA : ST_HS_TRAIL;
      end
      ST_HS_TRAIL: begin
        w_lp        = LP00;
        w_hs_en     = 1'b1;
        w_state_nxt = w_tmr_zero ? ST_HS_EXIT : ST_HS_TRAIL;
      end
      ST_HS_EXIT: begin
        w_end       = w_tmr_zero;
        w_state_nxt = w_tmr_zero ? ST_STOP : ST_HS_EXIT;
      end
      default: w_state_nxt = ST_STOP;
    endcase
  end

  assign w_accept   = w_ready & lane.TX_REQ;
  assign w_tmr_load = (w_state_nxt != r_state);

  always_comb begin
    w_tmr_val = '0;
    case (w_state_nxt)
      ST_HS_RQST:  w_tmr_val = CNT_W'(T_LPX - 1);
      ST_HS_PRPR:  w_tmr_val = CNT_W'(T_HS_PREPARE - 1);
      ST_HS_ZERO:  w_tmr_val = CNT_W'(T_HS_ZERO - 1);
      ST_HS_TRAIL: w_tmr_val = CNT_W'(T_HS_TRAIL - 1);
      ST_HS_EXIT:  w_tmr_val = CNT_W'(T_HS_EXIT - 1);
      default:     w_tmr_val = '0;
    endcase
  end

  // Trail fills with the complement of the last transmitted MSB, held for the whole trail.
  always_comb begin
    w_hs_data_nxt = '0;
    case (w_state_nxt)
      ST_HS_SYNC:  w_hs_data_nxt = DATA_W'(SYNC_BYTE);
      ST_HS_DATA:  w_hs_data_nxt = w_accept ? lane.TX_DATA : r_hs_data;
      ST_HS_TRAIL: w_hs_data_nxt = (r_state == ST_HS_TRAIL) ? r_hs_data
                                                             : {DATA_W{~r_hs_data[DATA_W-1]}};
      default:     w_hs_data_nxt = '0;
    endcase
  end

  dphy_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (TX_BYTE_clk),
    .i_rst      (TX_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  assign lane.Dp             = w_lp[1];
  assign lane.Dn             = w_lp[0];
  assign lane.HS_EN          = w_hs_en;
  assign lane.HS_DATA        = r_hs_data;
  assign lane.TX_READY       = w_ready;
  assign lane.TX_HS_END_DATA = w_end;
  assign lane.TX_STOP_STATE  = w_stop;

endmodule
